// File: rtl/mc_controller_pkg.sv
// Shared types and constants for the multicycle MIPS control FSM (mc_controller).
// The optional bne support is enabled with the MC_BNE_EN macro.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_BNE     = 4'd12
    } state_t;

    localparam state_t RESET_STATE = S_FETCH;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between mc_controller (master) and the multicycle datapath (slave).
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;

    modport master (
        input  op, funct, zero,
        output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, illegal
    );

    modport slave (
        output op, funct, zero,
        input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, illegal
    );
endinterface

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps the FSM's aluop and the instruction funct field to an ALU code.
// funct_valid is independent of aluop so DECODE can reject bad R-type functs early.
module mc_aludec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_valid
);

    logic [2:0] funct_alu_s;

    // Decode the R-type funct field into an ALU code and a legality flag.
    always_comb begin
        funct_valid = 1'b1;
        funct_alu_s = ALU_ADD;
        case (funct)
            FN_ADD:  funct_alu_s = ALU_ADD;
            FN_SUB:  funct_alu_s = ALU_SUB;
            FN_AND:  funct_alu_s = ALU_AND;
            FN_OR:   funct_alu_s = ALU_OR;
            FN_SLT:  funct_alu_s = ALU_SLT;
            default: begin
                funct_valid = 1'b0;
                funct_alu_s = ALU_ADD;
            end
        endcase
    end

    // Select the final ALU operation from the FSM's request.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD:   alucontrol = ALU_ADD;
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = funct_alu_s;
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: one state per cycle, datapath controls decoded from state.
// Define MC_BNE_EN to add the bne instruction; otherwise op 000101 is reported illegal.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    mc_controller_if.master  bus
);

    state_t     state_r;
    logic       illegal_r;

    logic       pcwrite_s;
    logic       branch_s;
    logic       branchne_s;
    logic       irwrite_s;
    logic       memwrite_s;
    logic       regwrite_s;
    logic       iord_s;
    logic       memtoreg_s;
    logic       regdst_s;
    logic       alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] pcsrc_s;
    logic [1:0] aluop_s;
    logic [2:0] alucontrol_s;
    logic       funct_valid_s;

    mc_aludec u_aludec (
        .aluop       (aluop_s),
        .funct       (bus.funct),
        .alucontrol  (alucontrol_s),
        .funct_valid (funct_valid_s)
    );

    // State sequencing and the one-cycle illegal-instruction pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= RESET_STATE;
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= 1'b0;
            case (state_r)
                S_FETCH:  state_r <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state_r <= S_MEMADR;
                        OP_RTYPE: begin
                            if (funct_valid_s) begin
                                state_r <= S_EXECUTE;
                            end else begin
                                state_r   <= S_FETCH;
                                illegal_r <= 1'b1;
                            end
                        end
                        OP_BEQ:  state_r <= S_BRANCH;
`ifdef MC_BNE_EN
                        OP_BNE:  state_r <= S_BNE;
`endif
                        OP_ADDI: state_r <= S_ADDIEX;
                        OP_J:    state_r <= S_JUMP;
                        default: begin
                            state_r   <= S_FETCH;
                            illegal_r <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    if (bus.op == OP_LW) begin
                        state_r <= S_MEMRD;
                    end else begin
                        state_r <= S_MEMWR;
                    end
                end
                S_MEMRD:   state_r <= S_MEMWB;
                S_EXECUTE: state_r <= S_ALUWB;
                S_ADDIEX:  state_r <= S_ADDIWB;
                default:   state_r <= S_FETCH;
            endcase
        end
    end

    // Per-state control decode; anything not named in a state stays at 0 / add.
    always_comb begin
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        branchne_s = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        iord_s     = 1'b0;
        memtoreg_s = 1'b0;
        regdst_s   = 1'b0;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'b00;
        pcsrc_s    = 2'b00;
        aluop_s    = ALUOP_ADD;
        case (state_r)
            S_FETCH: begin
                irwrite_s = 1'b1;
                pcwrite_s = 1'b1;
                alusrcb_s = 2'b01;
            end
            S_DECODE: alusrcb_s = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            S_MEMRD: iord_s = 1'b1;
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg_s = 1'b1;
            end
            S_MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTE: begin
                alusrca_s = 1'b1;
                aluop_s   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
                regdst_s   = 1'b1;
            end
            S_BRANCH: begin
                alusrca_s = 1'b1;
                aluop_s   = ALUOP_SUB;
                pcsrc_s   = 2'b01;
                branch_s  = 1'b1;
            end
`ifdef MC_BNE_EN
            S_BNE: begin
                alusrca_s  = 1'b1;
                aluop_s    = ALUOP_SUB;
                pcsrc_s    = 2'b01;
                branchne_s = 1'b1;
            end
`endif
            S_ADDIWB: regwrite_s = 1'b1;
            S_JUMP: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: aluop_s = ALUOP_ADD;
        endcase
    end

    // Write enables are gated by reset_n so they drop without waiting for a clock edge.
    assign bus.pcen       = reset_n & (pcwrite_s | (branch_s & bus.zero) | (branchne_s & ~bus.zero));
    assign bus.irwrite    = reset_n & irwrite_s;
    assign bus.memwrite   = reset_n & memwrite_s;
    assign bus.regwrite   = reset_n & regwrite_s;
    assign bus.iord       = iord_s;
    assign bus.memtoreg   = memtoreg_s;
    assign bus.regdst     = regdst_s;
    assign bus.alusrca    = alusrca_s;
    assign bus.alusrcb    = alusrcb_s;
    assign bus.pcsrc      = pcsrc_s;
    assign bus.alucontrol = alucontrol_s;
    assign bus.illegal    = illegal_r;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized scoreboard bench for mc_controller: per-cycle expected control vectors
// are derived from instruction classes and compared by an independent monitor.
module tb_mc_controller;

    typedef enum int {C_LW, C_SW, C_R, C_ADDI, C_BEQ, C_BNE, C_J, C_ILL} cls_t;
    typedef struct {
        logic [15:0] vec;
        int          tag;
    } exp_t;

    localparam logic [15:0] RST_VEC = {8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0};

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   tag;
    logic pend_ill;
    exp_t q[$];

    mc_controller_if bus ();

    mc_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    wire [15:0] act_vec = {bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.iord,
                           bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc,
                           bus.alucontrol, bus.illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int t, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s tag=%0d got=%b exp=%b", nm, t, act, exp);
        end
    endtask

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] f);
        case (op)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                               f == 6'b100101 || f == 6'b101010) ? C_R : C_ILL;
            6'b000100: return C_BEQ;
`ifdef MC_BNE_EN
            6'b000101: return C_BNE;
`endif
            6'b001000: return C_ADDI;
            6'b000010: return C_J;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic int ncyc(input cls_t c);
        case (c)
            C_LW:                 return 5;
            C_SW, C_R, C_ADDI:    return 4;
            C_BEQ, C_BNE, C_J:    return 3;
            default:              return 2;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs of cycle s of an instruction of class c.
    function automatic logic [15:0] exp_vec(input cls_t c, input int s, input logic z,
                                            input logic [5:0] f, input logic ill);
        logic pcen, irw, mw, rw, iord, mtr, rdst, srca;
        logic [1:0] srcb, psrc;
        logic [2:0] alu;
        {pcen, irw, mw, rw, iord, mtr, rdst, srca} = 8'b0;
        srcb = 2'b00; psrc = 2'b00; alu = 3'b010;
        if (s == 0) begin
            pcen = 1'b1; irw = 1'b1; srcb = 2'b01;
        end else if (s == 1) begin
            srcb = 2'b11;
        end else begin
            case (c)
                C_LW, C_SW: begin
                    if (s == 2) begin srca = 1'b1; srcb = 2'b10; end
                    else if (s == 3 && c == C_LW) iord = 1'b1;
                    else if (s == 3) begin iord = 1'b1; mw = 1'b1; end
                    else begin rw = 1'b1; mtr = 1'b1; end
                end
                C_R: begin
                    if (s == 2) begin srca = 1'b1; alu = alu_of(f); end
                    else begin rw = 1'b1; rdst = 1'b1; end
                end
                C_ADDI: begin
                    if (s == 2) begin srca = 1'b1; srcb = 2'b10; end
                    else rw = 1'b1;
                end
                C_BEQ, C_BNE: begin
                    srca = 1'b1; alu = 3'b110; psrc = 2'b01;
                    pcen = (c == C_BEQ) ? z : ~z;
                end
                C_J: begin psrc = 2'b10; pcen = 1'b1; end
                default: ;
            endcase
        end
        return {pcen, irw, mw, rw, iord, mtr, rdst, srca, srcb, psrc, alu, (s == 0) ? ill : 1'b0};
    endfunction

    // zmode: 0 random everywhere, 1 zero=1 outside branch, 2 zero=x outside branch; zb is branch-cycle zero.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode,
                             input logic zb, input int lim);
        cls_t c;
        int   n;
        logic z;
        logic brs;
        c = classify(op, f);
        n = ncyc(c);
        if (lim > 0 && lim < n) n = lim;
        bus.op = op;
        bus.funct = f;
        for (int s = 0; s < n; s++) begin
            brs = (c == C_BEQ || c == C_BNE) && s == 2;
            if (zmode == 0) z = 1'($urandom_range(0, 1));
            else if (brs) z = zb;
            else if (zmode == 1) z = 1'b1;
            else z = 1'bx;
            bus.zero = z;
            q.push_back('{exp_vec(c, s, brs ? z : 1'b0, f, (s == 0) ? pend_ill : 1'b0), tag * 8 + s});
            @(posedge clk);
            #1;
        end
        tag++;
        pend_ill = (n == ncyc(c)) && (c == C_ILL);
    endtask

    // Monitor: pops the scoreboard each cycle the driver has published an expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("step", e.tag, act_vec, e.vec);
            end
        end
    end

    initial begin
        logic [5:0] ops[9];
        logic [5:0] fns[5];
        logic [5:0] op;
        logic [5:0] f;
        checks = 0; errors = 0; tag = 0; pend_ill = 1'b0;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100,
                6'b000101, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        reset_n = 1'b0;
        bus.op = 6'b100011; bus.funct = 6'b000000; bus.zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", i, act_vec, RST_VEC);
        end
        reset_n = 1'b1;

        run_instr(6'b100011, 6'b000000, 0, 1'b0, 0);
        run_instr(6'b000000, 6'b101010, 0, 1'b0, 0);
        run_instr(6'b000100, 6'b000000, 1, 1'b1, 0);
        run_instr(6'b000100, 6'b000000, 1, 1'b0, 0);
        run_instr(6'b101011, 6'b000000, 2, 1'b0, 0);
        run_instr(6'b111111, 6'b000000, 0, 1'b0, 0);
        run_instr(6'b000000, 6'b000111, 0, 1'b0, 0);
        run_instr(6'b000101, 6'b000000, 1, 1'b0, 0);
        run_instr(6'b000101, 6'b000000, 1, 1'b1, 0);
        run_instr(6'b000010, 6'b000000, 2, 1'b0, 0);
        run_instr(6'b001000, 6'b000000, 0, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 8)];
            if (op == 6'b111111) op = 6'($urandom);
            f = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            run_instr(op, f, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        end

        // Asynchronous reset in the MEMWB cycle of a lw.
        run_instr(6'b100011, 6'b000000, 0, 1'b0, 4);
        chk("memwb_regwrite", tag, {15'b0, bus.regwrite}, 16'd1);
        #1 reset_n = 1'b0;
        #1 chk("async_reset", tag, act_vec, RST_VEC);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold2", i, act_vec, RST_VEC);
        end
        reset_n = 1'b1;
        pend_ill = 1'b0;
        run_instr(6'b000000, 6'b100010, 0, 1'b0, 0);
        run_instr(6'b110011, 6'b000000, 0, 1'b0, 0);
        run_instr(6'b101011, 6'b000000, 0, 1'b0, 0);

        repeat (2) @(negedge clk);
        chk("queue_drained", 0, 16'(q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
